// File: rtl/vector_lane_packer_pkg.sv
// Shared lane-count and lane-width constants for the vector lane packer,
// plus the packer's control-state encoding.
package vector_lane_packer_pkg;

  localparam int K_LANES     = 4;
  localparam int LANE_DATA_W = 32;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/vector_lane_packer_lane_register_bank.sv
// K x DATA_W register bank with per-lane write enables and a synchronous clear.
// The clear takes priority over any lane write in the same cycle.
module lane_register_bank
  import vector_lane_packer_pkg::*;
#(
  parameter int K      = K_LANES,
  parameter int DATA_W = LANE_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [K-1:0]          we,
  input  logic [K*DATA_W-1:0]   wdata,
  output logic [K*DATA_W-1:0]   q
);

  logic [K*DATA_W-1:0] lanes_q, lanes_d;

  always_comb begin
    lanes_d = lanes_q;
    if (clr) begin
      lanes_d = '0;
    end else begin
      for (int i = 0; i < K; i++) begin
        if (we[i]) lanes_d[i*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lanes_q <= '0;
    else        lanes_q <= lanes_d;
  end

  assign q = lanes_q;

endmodule

// File: rtl/vector_lane_packer.sv
// Serial-to-parallel packer: collects scalar words into a K-lane vector (lane 0 first)
// using a fill bank and an output bank so one word per cycle flows under backpressure.
module vector_lane_packer
  import vector_lane_packer_pkg::*;
#(
  parameter  int K      = K_LANES,
  parameter  int DATA_W = LANE_DATA_W,
  localparam int CNT_W  = $clog2(K + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [K*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]    out_count
);

  localparam int PTR_W = (K > 1) ? $clog2(K) : 1;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    held_cnt_q, held_cnt_d;

  logic [K-1:0]        lane_sel;
  logic [K-1:0]        fill_we, out_we;
  logic                fill_clr;
  logic [K*DATA_W-1:0] fill_q, merged, out_wdata;
  logic                accept, complete, out_free;
  logic [CNT_W-1:0]    cur_cnt;

  assign in_ready = (state_q == ST_FILL);
  assign accept   = in_valid & in_ready;
  assign complete = accept & (in_last | (wptr_q == PTR_W'(K - 1)));
  assign out_free = ~out_valid_q | out_ready;
  assign cur_cnt  = CNT_W'(wptr_q) + CNT_W'(1);

  // The completing word is still in flight when the vector is handed to the output
  // bank, so the output sees the fill bank with that word merged into its lane.
  always_comb begin
    merged = fill_q;
    for (int i = 0; i < K; i++) begin
      lane_sel[i] = (wptr_q == PTR_W'(i));
      if (lane_sel[i]) merged[i*DATA_W +: DATA_W] = in_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    out_valid_d = out_valid_q & ~out_ready;
    count_d     = count_q;
    held_cnt_d  = held_cnt_q;
    fill_we     = '0;
    fill_clr    = 1'b0;
    out_we      = '0;
    out_wdata   = merged;
    unique case (state_q)
      ST_FILL: begin
        if (complete && out_free) begin
          out_we      = '1;
          count_d     = cur_cnt;
          out_valid_d = 1'b1;
          fill_clr    = 1'b1;
          wptr_d      = '0;
        end else if (complete) begin
          fill_we    = lane_sel;
          held_cnt_d = cur_cnt;
          wptr_d     = '0;
          state_d    = ST_HOLD;
        end else if (accept) begin
          fill_we = lane_sel;
          wptr_d  = wptr_q + PTR_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_we      = '1;
          out_wdata   = fill_q;
          count_d     = held_cnt_q;
          out_valid_d = 1'b1;
          fill_clr    = 1'b1;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      wptr_q      <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      held_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      held_cnt_q  <= held_cnt_d;
    end
  end

  lane_register_bank #(.K(K), .DATA_W(DATA_W)) u_fill_bank (
    .clk   (clk),
    .rst_n (reset),
    .clr   (fill_clr),
    .we    (fill_we),
    .wdata ({K{in_data}}),
    .q     (fill_q)
  );

  lane_register_bank #(.K(K), .DATA_W(DATA_W)) u_out_bank (
    .clk   (clk),
    .rst_n (reset),
    .clr   (1'b0),
    .we    (out_we),
    .wdata (out_wdata),
    .q     (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_vector_lane_packer.sv
// Directed and randomized checks of vector_lane_packer with a transaction scoreboard.
module tb_vector_lane_packer;

  localparam int K  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, in_last;
  logic [DW-1:0]   in_data;
  logic            out_valid, out_ready;
  logic [K*DW-1:0] out_data;
  logic [2:0]      out_count;

  int errs   = 0;
  int checks = 0;

  logic [K*DW-1:0] exp_vec_q[$];
  logic [2:0]      exp_cnt_q[$];
  logic [K*DW-1:0] cur_vec;
  int              cur_n;
  bit              sb_en;

  vector_lane_packer #(.K(K), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard sees the pre-edge view: inputs are stable and outputs show current state.
  task automatic monitor();
    if (out_valid && out_ready) begin
      if (exp_vec_q.size() == 0) begin
        check("sb_unexpected_out", 1, 0);
      end else begin
        check("sb_data", out_data, exp_vec_q.pop_front());
        check("sb_count", {125'd0, out_count}, {125'd0, exp_cnt_q.pop_front()});
      end
    end
    if (in_valid && in_ready) begin
      cur_vec[cur_n*DW +: DW] = in_data;
      cur_n++;
      if (in_last || cur_n == K) begin
        exp_vec_q.push_back(cur_vec);
        exp_cnt_q.push_back(3'(cur_n));
        cur_vec = '0;
        cur_n   = 0;
      end
    end
  endtask

  task automatic tick();
    if (sb_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [127:0] d,
                           input logic [2:0] c);
    check({tag, "_valid"}, {127'd0, out_valid}, {127'd0, v});
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, {125'd0, out_count}, {125'd0, c});
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    sb_en = 1'b0; cur_vec = '0; cur_n = 0;
    tick(); tick();
    check_out("rst", 1'b0, 128'd0, 3'd0);
    reset = 1'b1;
    tick();
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Full vector, back-to-back
    out_ready = 1'b1;
    push(32'h11, 1'b0); push(32'h22, 1'b0); push(32'h33, 1'b0); push(32'h44, 1'b0);
    check_out("full", 1'b1, 128'h00000044_00000033_00000022_00000011, 3'd4);

    // Short vector, then next word lands in lane 0
    push(32'hA, 1'b0); push(32'hB, 1'b1);
    check_out("short", 1'b1, 128'h00000000_00000000_0000000B_0000000A, 3'd2);
    push(32'hC, 1'b1);
    check_out("short_next", 1'b1, 128'h00000000_00000000_00000000_0000000C, 3'd1);

    // Backpressure into HOLD
    tick();
    check("drain_valid", {127'd0, out_valid}, 128'd0);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("bp_rdy%0d", i), {127'd0, in_ready}, 128'd1);
      push(32'h100 + 32'(i), 1'b0);
    end
    check("hold_in_ready", {127'd0, in_ready}, 128'd0);
    check_out("hold", 1'b1, 128'h00000104_00000103_00000102_00000101, 3'd4);
    in_valid = 1'b1; in_data = 32'h109; in_last = 1'b1;
    tick();
    check("stall_in_ready", {127'd0, in_ready}, 128'd0);
    check_out("stall", 1'b1, 128'h00000104_00000103_00000102_00000101, 3'd4);
    out_ready = 1'b1;
    tick();
    check("release_in_ready", {127'd0, in_ready}, 128'd1);
    check_out("release", 1'b1, 128'h00000108_00000107_00000106_00000105, 3'd4);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check_out("ninth", 1'b1, 128'h00000000_00000000_00000000_00000109, 3'd1);

    // Reset mid-vector with an output pending
    out_ready = 1'b0;
    push(32'h55, 1'b0); push(32'h66, 1'b0);
    reset = 1'b0;
    #1;
    check_out("midrst", 1'b0, 128'd0, 3'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    out_ready = 1'b1;
    push(32'h77, 1'b1);
    check_out("after_rst", 1'b1, 128'h00000000_00000000_00000000_00000077, 3'd1);
    tick();

    // Streaming with out_ready held high
    sb_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check("stream_in_ready", {127'd0, in_ready}, 128'd1);
      push($urandom, ($urandom_range(0, 3) == 0) || (i == 39));
    end
    for (int i = 0; i < 3; i++) tick();
    check("stream_empty", 128'(exp_vec_q.size()), 128'd0);

    // Random valid/ready toggling
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rand_in_ready", {127'd0, in_ready}, 128'd1);
    push(32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("rand_empty", 128'(exp_vec_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
